i2c_arbiter: RTL

//  Shares one i2c byte engine between NREQ requesters, e.g. the ROM init sequencer, the HPD/EDID poller and AXI register access.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_arbiter_rr.sv | 36 +++
 rtl/i2c_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and helpers for the i2c arbiter slice.
// Rev 1.0 - initial release.
`default_nettype none

package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam int I2C_ARB_MAX_REQ = 8;

  // Bits needed to hold the value n itself, so a byte count of NBYTES always fits.
  function automatic int cl2(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
// Rev 1.0 - initial release.
`default_nettype none

module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c byte engine with NACK retry.
// Rev 1.0 - optional launch-to-ready abort timer enabled by I2C_ARB_TIMEOUT_EN.
`default_nettype none

module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int NBYTES    = 3,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ*cl2(NBYTES)-1:0]    req_nbytes_i,
  input  logic [NREQ*NBYTES*8-1:0]       req_data_i,
  output logic [NREQ-1:0]                gnt_o,
  output logic [NREQ-1:0]                ack_o,
  output logic [NBYTES-1:0]              rsp_status_o,
  output logic [NBYTES*8-1:0]            rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           i2c_send_o,
  output logic [cl2(NBYTES)-1:0]         i2c_nbytes_o,
  output logic [NBYTES*8-1:0]            i2c_data_o,
  input  logic                           i2c_done_i,
  input  logic                           i2c_ready_i,
  input  logic [NBYTES-1:0]              i2c_status_i,
  input  logic [NBYTES*8-1:0]            i2c_data_i
);

  localparam int NBW = cl2(NBYTES);
  localparam int DW  = NBYTES * 8;
  localparam int IW  = $clog2(I2C_ARB_MAX_REQ);
  localparam int RW  = cl2(MAX_RETRY);

  arb_state_e        state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_idx;
  logic [RW-1:0]     retry;
  logic              done_seen;
  logic [NBYTES-1:0] status_lat;
  logic [DW-1:0]     data_lat;
  logic [NBYTES-1:0] status_eff;
  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic              nack;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = cl2(TIMEOUT);
  logic [TW-1:0]     timer;
`else
  logic              unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Bytes beyond the transaction length never count as a NACK.
  always_comb begin
    status_eff = i2c_status_i;
    for (int b = 0; b < NBYTES; b++)
      if (b >= int'(i2c_nbytes_o)) status_eff[b] = 1'b1;
  end

  assign nack = ~&status_lat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      retry        <= '0;
      done_seen    <= 1'b0;
      status_lat   <= '0;
      data_lat     <= '0;
      gnt_o        <= '0;
      ack_o        <= '0;
      rsp_status_o <= '0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
      i2c_send_o   <= 1'b0;
      i2c_nbytes_o <= '0;
      i2c_data_o   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timer        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i2c_ready_i && pick_valid) begin
            gnt_o        <= pick_gnt;
            gnt_idx      <= pick_idx;
            i2c_nbytes_o <= req_nbytes_i[pick_idx*NBW +: NBW];
            i2c_data_o   <= req_data_i[pick_idx*DW +: DW];
            status_lat   <= '0;
            data_lat     <= '0;
            retry        <= '0;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          i2c_send_o <= 1'b1;
          done_seen  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
          timer      <= '0;
`endif
          state      <= BUSY;
        end
        BUSY: begin
          i2c_send_o <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
          timer      <= timer + 1'b1;
`endif
          if (i2c_done_i) begin
            status_lat <= status_eff;
            data_lat   <= i2c_data_i;
            done_seen  <= 1'b1;
          end
          if (done_seen && i2c_ready_i) begin
            if (nack && retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= LAUNCH;
            end else begin
              ack_o        <= gnt_o;
              rsp_status_o <= status_lat;
              rsp_data_o   <= data_lat;
              rsp_err_o    <= nack;
              state        <= RESP;
            end
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT - 1)) begin
            ack_o        <= gnt_o;
            rsp_status_o <= status_lat;
            rsp_data_o   <= data_lat;
            rsp_err_o    <= 1'b1;
            state        <= RESP;
          end
`endif
        end
        RESP: begin
          ack_o        <= '0;
          gnt_o        <= '0;
          rsp_status_o <= '0;
          rsp_data_o   <= '0;
          rsp_err_o    <= 1'b0;
          rr_ptr       <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
